// File: rtl/irq_vector_if.sv
// Interrupt source bus between the device/processor side and irq_vector_ctrl.
//   master : drives done, int_mask, int_ack, eoi, overrun_clr; observes results
//   slave  : the controller; receives requests and acks, drives interrupt,
//            int_addr, irq_id, pending, overrun, in_service and fsm_state
// Handshake: the controller holds interrupt high with a frozen irq_id/int_addr
// until the processor pulses int_ack for one cycle, or until the selected
// source is masked (withdraw). After an accepted ack, in_service stays high
// until a one-cycle eoi pulse; acks outside the request phase are ignored.
interface irq_vector_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] done;
    logic [NUM_SRC-1:0] int_mask;
    logic               int_ack;
    logic               eoi;
    logic               overrun_clr;
    logic               interrupt;
    logic [31:0]        int_addr;
    logic [2:0]         irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;
    logic               in_service;
    logic [1:0]         fsm_state;   // 0 = IDLE, 1 = REQ, 2 = SERVICE

    modport master (
        output done, int_mask, int_ack, eoi, overrun_clr,
        input  interrupt, int_addr, irq_id, pending, overrun, in_service, fsm_state
    );

    modport slave (
        input  done, int_mask, int_ack, eoi, overrun_clr,
        output interrupt, int_addr, irq_id, pending, overrun, in_service, fsm_state
    );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt source stage for a single-cycle MIPS core.
// Rising edges on device done lines become pending requests; the lowest-index
// unmasked pending request is presented to the processor as interrupt plus an
// ISR vector address, and the ack/eoi handshake allows one ISR at a time.
// Ports:
//   clk   - system clock, all state on posedge
//   reset - synchronous, active-high; clears every register
//   bus   - irq_vector_if slave modport (requests, ack/eoi, status outputs)
// All outputs come straight from flops.
module irq_vector_ctrl #(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0200,
    parameter int          VEC_SHIFT = 4
) (
    input logic         clk,
    input logic         reset,
    irq_vector_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [NUM_SRC-1:0] done_q,       done_d;
    logic [NUM_SRC-1:0] pending_q,    pending_d;
    logic [NUM_SRC-1:0] overrun_q,    overrun_d;
    logic               interrupt_q,  interrupt_d;
    logic [31:0]        int_addr_q,   int_addr_d;
    logic [2:0]         irq_id_q,     irq_id_d;
    logic               in_service_q, in_service_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] cur_onehot;
    logic [2:0]         sel_id;

    // Edge detect, fixed priority select, and a one-hot view of the frozen id.
    always_comb begin
        rise       = bus.done & ~done_q;
        req        = pending_q & bus.int_mask;
        sel_id     = '0;
        cur_onehot = '0;
        // Walk downward so the lowest requesting index is the last written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) sel_id = 3'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (irq_id_q == 3'(i)) cur_onehot[i] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        done_d       = bus.done;
        pending_d    = pending_q;
        interrupt_d  = interrupt_q;
        int_addr_d   = int_addr_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_REQ;
                    interrupt_d = 1'b1;
                    irq_id_d    = sel_id;
                    int_addr_d  = VEC_BASE + ({29'd0, sel_id} << VEC_SHIFT);
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    state_d      = ST_SERVICE;
                    interrupt_d  = 1'b0;
                    in_service_d = 1'b1;
                    pending_d    = pending_q & ~cur_onehot;
                end else if (!(|(bus.int_mask & cur_onehot))) begin
                    // Selected source masked while waiting: withdraw, keep it pending.
                    state_d     = ST_IDLE;
                    interrupt_d = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                interrupt_d = 1'b0;
            end
        endcase

        // A new edge always wins over the ack clear of the same source.
        pending_d = pending_d | rise;
        overrun_d = (bus.overrun_clr ? '0 : overrun_q) | (rise & pending_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            done_q       <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            interrupt_q  <= 1'b0;
            int_addr_q   <= '0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            interrupt_q  <= interrupt_d;
            int_addr_q   <= int_addr_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign bus.interrupt  = interrupt_q;
    assign bus.int_addr   = int_addr_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.pending    = pending_q;
    assign bus.overrun    = overrun_q;
    assign bus.in_service = in_service_q;
    assign bus.fsm_state  = state_q;

endmodule
